// File: rtl/ssm_bitpack_if.sv
// Block-in / word-out bus of the substream packer.
// BITPACK_BITCNT_EN adds the running packed-bit counter.
interface ssm_bitpack_if;
    logic         blk_vld;
    logic         blk_rdy;
    logic [1:0]   blk_mode;
    logic [2:0]   blk_flat;
    logic         blk_csc;
    logic [2:0]   blk_step;
    logic [127:0] blk_suffix;
    logic [7:0]   blk_size;
    logic         flush;
    logic [127:0] out_data;
    logic         out_vld;
    logic         out_rdy;
    logic         out_last;
    logic         flush_done;
`ifdef BITPACK_BITCNT_EN
    logic [31:0]  bit_cnt;
`endif

    modport master (
        output blk_vld, blk_mode, blk_flat, blk_csc, blk_step, blk_suffix, blk_size,
        output flush, out_rdy,
        input  blk_rdy, out_data, out_vld, out_last,
`ifdef BITPACK_BITCNT_EN
        input  flush_done, bit_cnt
`else
        input  flush_done
`endif
    );

    modport slave (
        input  blk_vld, blk_mode, blk_flat, blk_csc, blk_step, blk_suffix, blk_size,
        input  flush, out_rdy,
        output blk_rdy, out_data, out_vld, out_last,
`ifdef BITPACK_BITCNT_EN
        output flush_done, bit_cnt
`else
        output flush_done
`endif
    );
endinterface

// File: rtl/ssm_bitpack.sv
// Substream packer: header + suffix bits, MSB-first, into 128-bit words with zero-padded flush.
// Define BITPACK_BITCNT_EN to add the bit_cnt output (accepted block bits since last flush).
module ssm_bitpack #(
    parameter int unsigned SSM_IDX = 0
) (
    input logic          clk,
    input logic          rstn,
    ssm_bitpack_if.slave bus
);
    typedef enum logic {RUN, FLUSH} state_t;

    state_t         state_q, state_d;
    logic [255:0]   acc_q, acc_d;
    logic [8:0]     fill_q, fill_d;
    logic [1:0]     prev_mode_q, prev_mode_d;
    logic           flush_done_q, flush_done_d;

    logic           out_vld, out_last, emit, blk_rdy, accept;
    logic [2:0]     mode_fld, flat_fld;
    logic [3:0]     mode_len, flat_len, hdr_len;
    logic [9:0]     hdr;
    logic [127:0]   sfx, blk_bits;
    logic [8:0]     blk_len;

    assign out_vld  = (fill_q >= 9'd128) | ((state_q == FLUSH) & (fill_q != 9'd0));
    assign out_last = (state_q == FLUSH) & (fill_q != 9'd0) & (fill_q <= 9'd128);
    assign emit     = out_vld & bus.out_rdy;
    assign blk_rdy  = (state_q == RUN) & ((fill_q < 9'd128) | emit);
    assign accept   = bus.blk_vld & blk_rdy;

    // Block bit string, left-aligned in 128 bits; variable-length header fields are OR-ed in by shifting.
    always_comb begin
        mode_fld = (bus.blk_mode == prev_mode_q) ? 3'b100 : {1'b0, bus.blk_mode};
        mode_len = (bus.blk_mode == prev_mode_q) ? 4'd1 : 4'd3;
        flat_fld = (bus.blk_flat == 3'd4) ? 3'b000 : {1'b1, bus.blk_flat[1:0]};
        flat_len = (bus.blk_flat == 3'd4) ? 4'd1 : 4'd3;
        hdr      = {mode_fld, 7'b0}
                 | ({flat_fld, 7'b0} >> mode_len)
                 | ({bus.blk_csc, bus.blk_step, 6'b0} >> (mode_len + flat_len));
        hdr_len  = mode_len + flat_len + 4'd4;
        sfx      = bus.blk_suffix & ~({128{1'b1}} >> bus.blk_size);
        if (SSM_IDX == 0) begin
            blk_bits = {hdr, 118'b0} | (sfx >> hdr_len);
            blk_len  = {5'b0, hdr_len} + {1'b0, bus.blk_size};
        end else begin
            blk_bits = sfx;
            blk_len  = {1'b0, bus.blk_size};
        end
    end

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        fill_d       = fill_q;
        prev_mode_d  = prev_mode_q;
        flush_done_d = 1'b0;
        if (emit) begin
            acc_d  = {acc_q[127:0], 128'b0};
            fill_d = fill_q - 9'd128;
        end
        // The new block lands after whatever survives this cycle's emit.
        if (accept) begin
            acc_d       = acc_d | ({blk_bits, 128'b0} >> fill_d);
            fill_d      = fill_d + blk_len;
            prev_mode_d = bus.blk_mode;
        end
        case (state_q)
            RUN: begin
                if (bus.flush) begin
                    state_d = FLUSH;
                    fill_d  = (fill_d + 9'd127) & 9'h180;
                end
            end
            FLUSH: begin
                if ((fill_q == 9'd0) || (emit && out_last)) begin
                    state_d      = RUN;
                    flush_done_d = 1'b1;
                    prev_mode_d  = 2'd0;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= RUN;
            acc_q        <= '0;
            fill_q       <= '0;
            prev_mode_q  <= '0;
            flush_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            fill_q       <= fill_d;
            prev_mode_q  <= prev_mode_d;
            flush_done_q <= flush_done_d;
        end
    end

`ifdef BITPACK_BITCNT_EN
    logic [31:0] bit_cnt_q, bit_cnt_d;

    always_comb begin
        bit_cnt_d = bit_cnt_q;
        if (flush_done_d) begin
            bit_cnt_d = '0;
        end else if (accept) begin
            bit_cnt_d = bit_cnt_q + {23'b0, blk_len};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bit_cnt_q <= '0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
        end
    end

    assign bus.bit_cnt = bit_cnt_q;
`endif

    assign bus.blk_rdy    = blk_rdy;
    assign bus.out_data   = acc_q[255:128];
    assign bus.out_vld    = out_vld;
    assign bus.out_last   = out_last;
    assign bus.flush_done = flush_done_q;
endmodule
